// File: rtl/fetch_arb.sv
`default_nettype none
// ============================================================================
// Module   : fetch_arb
// Purpose  : Shares one line fetch/writeback engine between n_req cache-side
//            requesters. One requester owns the engine from selection until
//            the engine's fetch_done; gnt/done pulses are routed back to the
//            owner only.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_fetch_req_i     per-requester request, held until its gnt
//   req_fetch_cmd_i     packed 2-bit commands, slice i = [2i+1:2i]
//   req_fetch_tag_i     packed TW-bit line tags
//   req_fetch_addr_i    packed addr_width-bit line addresses
//   req_fetch_gnt_o     one-hot grant pulse to the owner
//   req_fetch_done_o    one-hot completion pulse to the owner
//   fetch_req_o         command valid towards the engine
//   fetch_cmd_o/tag_o/addr_o  latched command fields of the owner
//   fetch_gnt_i         engine accepts the command
//   fetch_done_i        engine finished the command (1-cycle pulse)
//   arb_busy_o          engine is owned (ISSUE or BUSY)
//   arb_owner_o         current / last owner ID
// Configuration
//   FETCH_ARB_FIXED_PRI_EN  defined: fixed priority, lowest index wins and
//                           the round-robin pointer does not exist.
//                           undefined (default): round-robin arbitration.
// ============================================================================
module fetch_arb #(
    parameter  int addr_width = 32,
    parameter  int list_depth = 4,
    parameter  int n_req      = 2,
    localparam int TW         = $clog2(list_depth),
    localparam int IW         = $clog2(n_req)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [n_req-1:0]           req_fetch_req_i,
    input  logic [2*n_req-1:0]         req_fetch_cmd_i,
    input  logic [TW*n_req-1:0]        req_fetch_tag_i,
    input  logic [addr_width*n_req-1:0] req_fetch_addr_i,
    output logic [n_req-1:0]           req_fetch_gnt_o,
    output logic [n_req-1:0]           req_fetch_done_o,
    output logic                       fetch_req_o,
    output logic [1:0]                 fetch_cmd_o,
    output logic [TW-1:0]              fetch_tag_o,
    output logic [addr_width-1:0]      fetch_addr_o,
    input  logic                       fetch_gnt_i,
    input  logic                       fetch_done_i,
    output logic                       arb_busy_o,
    output logic [IW-1:0]              arb_owner_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [TW-1:0]         tag_q, tag_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [IW-1:0]         win;
    logic [n_req-1:0]      owner_oh;

`ifdef FETCH_ARB_FIXED_PRI_EN
    // Lowest set index wins.
    always_comb begin
        win = '0;
        for (int i = n_req - 1; i >= 0; i--) begin
            if (req_fetch_req_i[i]) win = IW'(i);
        end
    end
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] win_lo, win_hi;
    logic          found_hi;
    logic          complete;

    // Round robin: lowest set index at or above rr_ptr, otherwise wrap to
    // the lowest set index overall. Scanning downwards leaves the lowest hit.
    always_comb begin
        win_lo   = '0;
        win_hi   = '0;
        found_hi = 1'b0;
        for (int i = n_req - 1; i >= 0; i--) begin
            if (req_fetch_req_i[i]) begin
                win_lo = IW'(i);
                if (IW'(i) >= rr_ptr_q) begin
                    win_hi   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    // Pointer only advances when a command completes, not on reset abort.
    assign complete = fetch_done_i &&
                      (((state_q == S_ISSUE) && fetch_gnt_i) || (state_q == S_BUSY));

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (complete) begin
            rr_ptr_d = (owner_q == IW'(n_req - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        for (int i = 0; i < n_req; i++) owner_oh[i] = (owner_q == IW'(i));
    end

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        cmd_d            = cmd_q;
        tag_d            = tag_q;
        addr_d           = addr_q;
        fetch_req_o      = 1'b0;
        req_fetch_gnt_o  = '0;
        req_fetch_done_o = '0;
        case (state_q)
            S_IDLE: begin
                // fetch_done here belongs to nobody and is dropped.
                if (|req_fetch_req_i) begin
                    owner_d = win;
                    for (int i = 0; i < n_req; i++) begin
                        if (win == IW'(i)) begin
                            cmd_d  = req_fetch_cmd_i[2*i +: 2];
                            tag_d  = req_fetch_tag_i[TW*i +: TW];
                            addr_d = req_fetch_addr_i[addr_width*i +: addr_width];
                        end
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fetch_req_o = 1'b1;
                if (fetch_gnt_i) begin
                    req_fetch_gnt_o = owner_oh;
                    if (fetch_done_i) begin
                        req_fetch_done_o = owner_oh;
                        state_d          = S_IDLE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (fetch_done_i) begin
                    req_fetch_done_o = owner_oh;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            cmd_q   <= '0;
            tag_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
        end
    end

    assign fetch_cmd_o  = cmd_q;
    assign fetch_tag_o  = tag_q;
    assign fetch_addr_o = addr_q;
    assign arb_busy_o   = (state_q != S_IDLE);
    assign arb_owner_o  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_arb
// Purpose  : Self-checking bench for fetch_arb (n_req=2, list_depth=4,
//            addr_width=32): directed transaction table, hand-written reset
//            and back-to-back sequences, then randomized traffic compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_arb;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int TW = 2;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i;
    logic [2*N-1:0]  cmd_i;
    logic [TW*N-1:0] tag_i;
    logic [AW*N-1:0] addr_i;
    logic [N-1:0]    gnt_o, done_o;
    logic            fetch_req_o;
    logic [1:0]      fetch_cmd_o;
    logic [TW-1:0]   fetch_tag_o;
    logic [AW-1:0]   fetch_addr_o;
    logic            fetch_gnt, fetch_done;
    logic            busy_o;
    logic [IW-1:0]   owner_o;

    int total = 0;
    int bad   = 0;

    fetch_arb #(.addr_width(AW), .list_depth(4), .n_req(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_fetch_req_i(req_i), .req_fetch_cmd_i(cmd_i),
        .req_fetch_tag_i(tag_i), .req_fetch_addr_i(addr_i),
        .req_fetch_gnt_o(gnt_o), .req_fetch_done_o(done_o),
        .fetch_req_o(fetch_req_o), .fetch_cmd_o(fetch_cmd_o),
        .fetch_tag_o(fetch_tag_o), .fetch_addr_o(fetch_addr_o),
        .fetch_gnt_i(fetch_gnt), .fetch_done_i(fetch_done),
        .arb_busy_o(busy_o), .arb_owner_o(owner_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

`ifdef FETCH_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // Table fields belong to requester 1; requester 0 drives their inverse,
    // so the latched fields also identify the winner.
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] addr;
        int          gdly;
        int          ddly;
        int          exp_rr;
        int          exp_fp;
    } vec_t;

    vec_t vecs[7];

    // Called at a falling edge with the DUT idle; returns one falling edge
    // (+1) after the arbiter is back in IDLE.
    task automatic run_txn(input logic [1:0] req, input logic [1:0] cmd,
                           input logic [1:0] tag, input logic [31:0] addr,
                           input int gdly, input int ddly, input int exp, input int id);
        logic [1:0]  oh, ecmd, etag;
        logic [31:0] eaddr;
        oh    = (exp == 1) ? 2'b10 : 2'b01;
        ecmd  = (exp == 1) ? cmd  : ~cmd;
        etag  = (exp == 1) ? tag  : ~tag;
        eaddr = (exp == 1) ? addr : ~addr;
        req_i  = req;
        cmd_i  = {cmd, ~cmd};
        tag_i  = {tag, ~tag};
        addr_i = {addr, ~addr};
        #1 chk($sformatf("v%0d idle_fetch_req", id), fetch_req_o, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d fetch_req", id), fetch_req_o, 1);
        chk($sformatf("v%0d owner", id), owner_o, exp);
        chk($sformatf("v%0d cmd", id), fetch_cmd_o, ecmd);
        chk($sformatf("v%0d tag", id), fetch_tag_o, etag);
        chk($sformatf("v%0d addr", id), fetch_addr_o, eaddr);
        chk($sformatf("v%0d busy", id), busy_o, 1);
        @(negedge clk);
        req_i  = '0;      // dropped after selection: must not matter
        cmd_i  = '0;
        tag_i  = '0;
        addr_i = '0;
        for (int k = 0; k < gdly; k++) begin
            #1;
            chk($sformatf("v%0d stall_gnt", id), gnt_o, 0);
            chk($sformatf("v%0d stall_req", id), fetch_req_o, 1);
            chk($sformatf("v%0d stall_fields", id),
                {fetch_cmd_o, fetch_tag_o, fetch_addr_o}, {ecmd, etag, eaddr});
            @(negedge clk);
        end
        fetch_gnt  = 1'b1;
        fetch_done = (ddly == 0);
        #1;
        chk($sformatf("v%0d gnt", id), gnt_o, oh);
        chk($sformatf("v%0d gnt_done", id), done_o, (ddly == 0) ? oh : 2'b00);
        @(negedge clk);
        fetch_gnt  = 1'b0;
        fetch_done = 1'b0;
        if (ddly > 0) begin
            for (int k = 0; k < ddly - 1; k++) begin
                #1;
                chk($sformatf("v%0d busy_req", id), {fetch_req_o, busy_o, gnt_o, done_o}, 6'b010000);
                @(negedge clk);
            end
            fetch_done = 1'b1;
            #1 chk($sformatf("v%0d done", id), done_o, oh);
            @(negedge clk);
            fetch_done = 1'b0;
        end
        #1 chk($sformatf("v%0d idle_after", id), busy_o, 0);
    endtask

    // Reference model state for the random phase.
    int          m_phase;   // 0 free, 1 command offered, 2 engine working
    int          m_owner, m_ptr, w;
    logic [1:0]  m_cmd, m_tag;
    logic [31:0] m_addr;
    logic [1:0]  pend, drv, e_gnt, e_done;
    logic [1:0]  rc[N], rt[N];
    logic [31:0] ra[N];
    logic        g, d;

    initial begin
        vecs[0] = '{2'b10, 2'b01, 2'd2, 32'h0000_1040, 2, 3, 1, 1};
        vecs[1] = '{2'b11, 2'b10, 2'd1, 32'h0000_2000, 0, 1, 0, 0};
        vecs[2] = '{2'b11, 2'b11, 2'd0, 32'hDEAD_BE00, 10, 2, 1, 0};
        vecs[3] = '{2'b01, 2'b00, 2'd3, 32'h1234_5600, 1, 0, 0, 0};
        vecs[4] = '{2'b01, 2'b01, 2'd1, 32'h0F0F_0F00, 0, 4, 0, 0};
        vecs[5] = '{2'b11, 2'b10, 2'd2, 32'hA5A5_0000, 3, 1, 1, 0};
        vecs[6] = '{2'b10, 2'b11, 2'd3, 32'h8000_0040, 0, 0, 1, 1};

        rst_n = 1'b0; req_i = '0; cmd_i = '0; tag_i = '0; addr_i = '0;
        fetch_gnt = 1'b0; fetch_done = 1'b0;
        #1;
        chk("reset_outputs", {fetch_req_o, fetch_cmd_o, fetch_tag_o, fetch_addr_o,
                              gnt_o, done_o, busy_o, owner_o}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // fetch_done while idle: no pulse.
        fetch_done = 1'b1;
        #1 chk("idle_done_ignored", {done_o, busy_o}, 0);
        @(negedge clk);
        fetch_done = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].req, vecs[i].cmd, vecs[i].tag, vecs[i].addr,
                    vecs[i].gdly, vecs[i].ddly,
                    FIXED ? vecs[i].exp_fp : vecs[i].exp_rr, i);
        end

        // Reset while BUSY, then re-arbitration from pointer 0.
        run_txn(2'b01, 2'b00, 2'd0, 32'h0, 0, 1, 0, 7);
        req_i = 2'b11;
        @(posedge clk); #1;
        chk("pre_reset_owner", owner_o, FIXED ? 0 : 1);
        @(negedge clk);
        fetch_gnt = 1'b1;
        @(negedge clk);
        fetch_gnt = 1'b0;
        #1 chk("pre_reset_busy", busy_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {fetch_req_o, fetch_cmd_o, fetch_tag_o, fetch_addr_o,
                                    gnt_o, done_o, busy_o, owner_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_owner", owner_o, 0);
        chk("post_reset_req", fetch_req_o, 1);
        @(negedge clk);
        fetch_gnt = 1'b1; fetch_done = 1'b1;
        #1 chk("post_reset_gnt", {gnt_o, done_o}, 4'b0101);
        @(negedge clk);
        fetch_gnt = 1'b0; fetch_done = 1'b0;

        // Both held continuously: alternation (or fixed priority), next
        // fetch_req two cycles after done.
        for (int j = 0; j < 4; j++) begin
            #1 chk($sformatf("held%0d gap", j), fetch_req_o, 0);
            @(posedge clk); #1;
            chk($sformatf("held%0d owner", j), owner_o, FIXED ? 0 : ((j % 2 == 0) ? 1 : 0));
            @(negedge clk);
            fetch_gnt = 1'b1; fetch_done = 1'b1;
            #1 chk($sformatf("held%0d pulses", j), {gnt_o, done_o},
                   (FIXED || j % 2 == 1) ? 4'b0101 : 4'b1010);
            @(negedge clk);
            fetch_gnt = 1'b0; fetch_done = 1'b0;
        end
        req_i = 2'b10;
        @(posedge clk); #1;
        chk("held_drop0_owner", owner_o, 1);
        @(negedge clk);
        req_i = 2'b00;
        fetch_gnt = 1'b1; fetch_done = 1'b1;
        #1 chk("held_drop0_pulses", {gnt_o, done_o}, 4'b1010);
        @(negedge clk);
        fetch_gnt = 1'b0; fetch_done = 1'b0;

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = 0; m_owner = 0; m_ptr = 0;
        m_cmd = '0; m_tag = '0; m_addr = '0;
        pend = '0;
        for (int i = 0; i < N; i++) begin rc[i] = '0; rt[i] = '0; ra[i] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 4 == 0)) begin
                    pend[i] = 1'b1;
                    rc[i] = 2'($urandom);
                    rt[i] = 2'($urandom);
                    ra[i] = $urandom;
                end
            end
            drv    = pend;
            req_i  = drv;
            cmd_i  = {rc[1], rc[0]};
            tag_i  = {rt[1], rt[0]};
            addr_i = {ra[1], ra[0]};
            g = 1'b0;
            d = 1'b0;
            if (m_phase == 0) d = ($urandom % 8 == 0);
            if (m_phase == 1) begin
                g = ($urandom % 3 == 0);
                d = g && ($urandom % 3 == 0);
            end
            if (m_phase == 2) d = ($urandom % 3 == 0);
            fetch_gnt  = g;
            fetch_done = d;
            e_gnt  = (m_phase == 1 && g) ? 2'(1 << m_owner) : 2'b00;
            e_done = (d && ((m_phase == 1 && g) || m_phase == 2)) ? 2'(1 << m_owner) : 2'b00;
            #1;
            chk("rnd fetch_req", fetch_req_o, m_phase == 1);
            chk("rnd busy", busy_o, m_phase != 0);
            chk("rnd owner", owner_o, m_owner);
            chk("rnd gnt", gnt_o, e_gnt);
            chk("rnd done", done_o, e_done);
            if (m_phase != 0)
                chk("rnd fields", {fetch_cmd_o, fetch_tag_o, fetch_addr_o}, {m_cmd, m_tag, m_addr});
            @(posedge clk);
            pend = pend & ~e_gnt;
            if (m_phase == 0) begin
                if (drv != 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && drv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    m_owner = w;
                    m_cmd = rc[w]; m_tag = rt[w]; m_addr = ra[w];
                    m_phase = 1;
                end
            end else if (e_done != 0) begin
                m_phase = 0;
                m_ptr   = FIXED ? 0 : (m_owner + 1) % N;
            end else if (e_gnt != 0) begin
                m_phase = 2;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
